// File: rtl/hdmi_pkg.sv
// Shared types and default frame geometry for the HDMI upscale path.
package hdmi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // Default 480p output raster and NES input raster.
    localparam int DEF_OFRAME_WIDTH   = 858;
    localparam int DEF_OFRAME_HEIGHT  = 525;
    localparam int DEF_OSCREEN_WIDTH  = 720;
    localparam int DEF_ISCREEN_WIDTH  = 256;
    localparam int DEF_ISCREEN_HEIGHT = 240;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Output raster counters: column hx, row hy and the vertical replication
// phase sub_hy, plus end-of-line / end-of-frame strobes decoded from them.
module hdmi_raster_counter import hdmi_pkg::*; #(
    parameter int OFRAME_WIDTH  = DEF_OFRAME_WIDTH,
    parameter int OFRAME_HEIGHT = DEF_OFRAME_HEIGHT,
    parameter int SUB_Y         = 2,
    parameter int SY_W          = width_of(SUB_Y)
) (
    input  logic            clk_h,
    input  logic            rst_h_n,
    output logic [9:0]      hx,
    output logic [9:0]      hy,
    output logic [SY_W-1:0] sub_hy,
    output logic            line_end,
    output logic            frame_end
);

    localparam logic [9:0]      HX_LAST    = 10'(OFRAME_WIDTH - 1);
    localparam logic [9:0]      HY_LAST    = 10'(OFRAME_HEIGHT - 1);
    localparam logic [SY_W-1:0] SUB_Y_LAST = SY_W'(SUB_Y - 1);

    assign line_end  = (hx == HX_LAST);
    assign frame_end = line_end && (hy == HY_LAST);

    // Free-running raster; sub_hy realigns to zero at every frame wrap so an
    // odd frame height does not skew the replication phase.
    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            hx     <= '0;
            hy     <= '0;
            sub_hy <= '0;
        end else begin
            hx <= line_end ? 10'd0 : hx + 10'd1;
            if (line_end) begin
                hy <= frame_end ? 10'd0 : hy + 10'd1;
                if (frame_end || (sub_hy == SUB_Y_LAST)) begin
                    sub_hy <= '0;
                end else begin
                    sub_hy <= sub_hy + SY_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/hdmi_scan_sequencer.sv
// Output raster sequencer for the HDMI upscale path: pillarbox draw window,
// line-buffer read index, per-input-line copy strobe, PPU frame request and
// the frame-lock FSM that gates NES pixels.
// Optional build macro HDMI_SEQ_STATS_EN: enables the saturating resync_cnt
// register counting LOCKED->SEEK transitions; otherwise resync_cnt reads 0.
module hdmi_scan_sequencer import hdmi_pkg::*; #(
    parameter int OFRAME_WIDTH    = DEF_OFRAME_WIDTH,
    parameter int OFRAME_HEIGHT   = DEF_OFRAME_HEIGHT,
    parameter int OSCREEN_WIDTH   = DEF_OSCREEN_WIDTH,
    parameter int ISCREEN_WIDTH   = DEF_ISCREEN_WIDTH,
    parameter int ISCREEN_HEIGHT  = DEF_ISCREEN_HEIGHT,
    parameter int SUB_X           = 2,
    parameter int SUB_Y           = 2,
    parameter int OSCREEN_SHIFT   = (OSCREEN_WIDTH - ISCREEN_WIDTH * SUB_X) / 2,
    parameter int PRERENDER_LINES = 1,
    parameter int LOCK_TOL        = 2,
    parameter int MISS_MAX        = 3
) (
    input  logic       clk_h,
    input  logic       rst_h_n,
    input  logic       enable,
    input  logic       ppu_frame_i,
    output logic [9:0] hx,
    output logic [9:0] hy,
    output logic       hdmi_on,
    output logic       nes_on,
    output logic [7:0] rd_idx,
    output logic       load_iline,
    output logic       new_frame,
    output logic       locked,
    output logic [1:0] lock_state,
    output logic [7:0] resync_cnt
);

    localparam int SY_W     = width_of(SUB_Y);
    localparam int MISS_W   = width_of(MISS_MAX);
    localparam int SX_SHIFT = $clog2(SUB_X);
    localparam int NF_LINE  = OFRAME_HEIGHT - SUB_Y * (PRERENDER_LINES + 1);

    localparam logic [9:0]      VIS_W      = 10'(OSCREEN_WIDTH);
    localparam logic [9:0]      VIS_H      = 10'(ISCREEN_HEIGHT * SUB_Y);
    localparam logic [9:0]      WIN_LO     = 10'(OSCREEN_SHIFT);
    localparam logic [9:0]      WIN_HI     = 10'(OSCREEN_SHIFT + ISCREEN_WIDTH * SUB_X);
    localparam logic [9:0]      NF_HY      = 10'(NF_LINE);
    localparam logic [9:0]      LOCK_HI    = 10'(NF_LINE + LOCK_TOL);
    localparam logic [9:0]      EVAL_HY    = 10'(NF_LINE + LOCK_TOL + 1);
    localparam logic [SY_W-1:0] SUB_Y_LAST = SY_W'(SUB_Y - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

    logic [SY_W-1:0]   sub_hy;
    logic              line_end;
    logic              frame_end;

    lock_state_t       state, state_next;
    logic [MISS_W-1:0] miss, miss_next;
    logic              hit, hit_next;
    logic              stray, stray_next;

    logic              in_window;
    logic [9:0]        hx_off;
    logic              lock_win;
    logic              eval_pt;
    logic              frame_good;

    hdmi_raster_counter #(
        .OFRAME_WIDTH  (OFRAME_WIDTH),
        .OFRAME_HEIGHT (OFRAME_HEIGHT),
        .SUB_Y         (SUB_Y),
        .SY_W          (SY_W)
    ) u_raster (
        .clk_h     (clk_h),
        .rst_h_n   (rst_h_n),
        .hx        (hx),
        .hy        (hy),
        .sub_hy    (sub_hy),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // Zero-latency raster decodes.
    assign hdmi_on    = (hx < VIS_W) && (hy < VIS_H);
    assign in_window  = hdmi_on && (hx >= WIN_LO) && (hx < WIN_HI);
    assign hx_off     = hx - WIN_LO;
    assign rd_idx     = in_window ? 8'(hx_off >> SX_SHIFT) : 8'd0;
    assign nes_on     = in_window && (state == LOCKED);
    assign load_iline = line_end && ((sub_hy == SUB_Y_LAST) || frame_end);
    assign new_frame  = (hy == NF_HY) && (state != IDLE);
    assign locked     = (state == LOCKED);
    assign lock_state = state;

    // Lock window: PPU frame start expected from NF_LINE up to LOCK_TOL lines late.
    assign lock_win   = (hy >= NF_HY) && (hy <= LOCK_HI);
    assign eval_pt    = (hx == 10'd0) && (hy == EVAL_HY);
    assign frame_good = hit && !stray;

    // FSM and flag registers.
    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            state <= IDLE;
            miss  <= '0;
            hit   <= 1'b0;
            stray <= 1'b0;
        end else begin
            state <= state_next;
            miss  <= miss_next;
            hit   <= hit_next;
            stray <= stray_next;
        end
    end

    // Next-state logic. Evaluation uses the flags registered before the
    // evaluation cycle; a pulse landing in that cycle falls outside every
    // window and is carried into the next frame as stray.
    always_comb begin
        state_next = state;
        miss_next  = miss;
        hit_next   = hit;
        stray_next = stray;

        if (eval_pt) begin
            hit_next   = 1'b0;
            stray_next = 1'b0;
        end
        if (ppu_frame_i) begin
            if (lock_win) begin
                hit_next = 1'b1;
            end else begin
                stray_next = 1'b1;
            end
        end

        unique case (state)
            IDLE: begin
                state_next = SEEK;
            end
            SEEK: begin
                if (eval_pt && frame_good) begin
                    state_next = LOCKED;
                    miss_next  = '0;
                end
            end
            LOCKED: begin
                if (eval_pt) begin
                    if (frame_good) begin
                        miss_next = '0;
                    end else if (miss == MISS_LAST) begin
                        state_next = SEEK;
                        miss_next  = '0;
                    end else begin
                        miss_next = miss + MISS_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!enable) begin
            state_next = IDLE;
            miss_next  = '0;
            hit_next   = 1'b0;
            stray_next = 1'b0;
        end
    end

`ifdef HDMI_SEQ_STATS_EN
    logic resync_evt;
    assign resync_evt = (state == LOCKED) && (state_next == SEEK);

    // Saturating count of lock losses; survives enable drops, clears on reset.
    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            resync_cnt <= '0;
        end else if (resync_evt && (resync_cnt != 8'hFF)) begin
            resync_cnt <= resync_cnt + 8'd1;
        end
    end
`else
    assign resync_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hdmi_scan_sequencer.sv
// Randomized bench for hdmi_scan_sequencer on a shrunken raster, compared
// cycle by cycle against a frame-arithmetic reference model.
module tb_hdmi_scan_sequencer;

    localparam int W     = 24;
    localparam int H     = 21;
    localparam int OSW   = 20;
    localparam int IW    = 8;
    localparam int IH    = 8;
    localparam int SX    = 2;
    localparam int SY    = 2;
    localparam int SHIFT = (OSW - IW * SX) / 2;
    localparam int PRE   = 1;
    localparam int TOL   = 2;
    localparam int MMAX  = 3;
    localparam int NF    = H - SY * (PRE + 1);
    localparam int EVAL_HY = NF + TOL + 1;
    localparam int FRAME = W * H;
    // Odd lines 1..19 plus the last line 20.
    localparam int LOADS_PER_FRAME = 11;

    logic       clk;
    logic       rst_h_n;
    logic       enable;
    logic       ppu_frame_i;
    logic [9:0] hx;
    logic [9:0] hy;
    logic       hdmi_on;
    logic       nes_on;
    logic [7:0] rd_idx;
    logic       load_iline;
    logic       new_frame;
    logic       locked;
    logic [1:0] lock_state;
    logic [7:0] resync_cnt;

    hdmi_scan_sequencer #(
        .OFRAME_WIDTH    (W),
        .OFRAME_HEIGHT   (H),
        .OSCREEN_WIDTH   (OSW),
        .ISCREEN_WIDTH   (IW),
        .ISCREEN_HEIGHT  (IH),
        .SUB_X           (SX),
        .SUB_Y           (SY),
        .PRERENDER_LINES (PRE),
        .LOCK_TOL        (TOL),
        .MISS_MAX        (MMAX)
    ) dut (
        .clk_h       (clk),
        .rst_h_n     (rst_h_n),
        .enable      (enable),
        .ppu_frame_i (ppu_frame_i),
        .hx          (hx),
        .hy          (hy),
        .hdmi_on     (hdmi_on),
        .nes_on      (nes_on),
        .rd_idx      (rd_idx),
        .load_iline  (load_iline),
        .new_frame   (new_frame),
        .locked      (locked),
        .lock_state  (lock_state),
        .resync_cnt  (resync_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raster position is just elapsed cycles since reset.
    int t = 0;
    int m_state = 0;   // 0 idle, 1 seeking, 2 locked
    int m_miss = 0;
    int m_resync = 0;
    bit m_hit = 1'b0;
    bit m_stray = 1'b0;

    always @(posedge clk) begin
        int e_hx, e_hy;
        bit eval, inwin, good;
        if (!rst_h_n) begin
            t = 0; m_state = 0; m_miss = 0; m_resync = 0; m_hit = 0; m_stray = 0;
        end else begin
            e_hx  = t % W;
            e_hy  = (t / W) % H;
            eval  = (e_hx == 0) && (e_hy == EVAL_HY);
            inwin = (e_hy >= NF) && (e_hy <= NF + TOL);
            good  = m_hit && !m_stray;
            if (!enable) begin
                m_state = 0; m_miss = 0; m_hit = 0; m_stray = 0;
            end else begin
                if (m_state == 0) begin
                    m_state = 1;
                end else if (eval) begin
                    if (good) begin
                        m_state = 2;
                        m_miss  = 0;
                    end else if (m_state == 2) begin
                        m_miss++;
                        if (m_miss == MMAX) begin
                            m_state = 1;
                            m_miss  = 0;
                            if (m_resync < 255) m_resync++;
                        end
                    end
                end
                if (eval) begin
                    m_hit = 0;
                    m_stray = 0;
                end
                if (ppu_frame_i) begin
                    if (inwin) m_hit = 1; else m_stray = 1;
                end
            end
            t = (t + 1) % FRAME;
        end
    end

    function automatic int exp_resync();
`ifdef HDMI_SEQ_STATS_EN
        return m_resync;
`else
        return 0;
`endif
    endfunction

    // Per-cycle comparison of every output against the model.
    int  load_seen = 0;
    bit  full_frame = 1'b0;
    always @(negedge clk) begin
        int e_hx, e_hy, e_rd;
        bit e_hdmi, e_win, e_load;
        if (chk_en) begin
            e_hx   = t % W;
            e_hy   = (t / W) % H;
            e_hdmi = (e_hx < OSW) && (e_hy < IH * SY);
            e_win  = e_hdmi && (e_hx >= SHIFT) && (e_hx < SHIFT + IW * SX);
            e_rd   = e_win ? (e_hx - SHIFT) / SX : 0;
            e_load = (e_hx == W - 1) && ((e_hy % SY == SY - 1) || (e_hy == H - 1));
            check_val("hx", hx, e_hx);
            check_val("hy", hy, e_hy);
            check_val("hdmi_on", hdmi_on, e_hdmi);
            check_val("nes_on", nes_on, e_win && (m_state == 2));
            check_val("rd_idx", rd_idx, e_rd);
            check_val("load_iline", load_iline, e_load);
            check_val("new_frame", new_frame, (e_hy == NF) && (m_state != 0));
            check_val("locked", locked, m_state == 2);
            check_val("lock_state", lock_state, m_state);
            check_val("resync_cnt", resync_cnt, exp_resync());

            if (e_hx == 0 && e_hy == 0) begin
                load_seen  = 0;
                full_frame = rst_h_n;
            end
            if (!rst_h_n) full_frame = 1'b0;
            if (load_iline === 1'b1) load_seen++;
            if (e_hx == W - 1 && e_hy == H - 1 && full_frame) begin
                check_val("loads_per_frame", load_seen, LOADS_PER_FRAME);
                full_frame = 1'b0;
            end
        end
    end

    // Stimulus: up to two planned PPU pulses per frame at (hy, hx) targets.
    int a_hy = -1, a_hx = 0, b_hy = -1, b_hx = 0;

    task automatic cycle();
        int c_hx, c_hy;
        @(negedge clk);
        c_hx = t % W;
        c_hy = (t / W) % H;
        ppu_frame_i = ((c_hy == a_hy) && (c_hx == a_hx)) || ((c_hy == b_hy) && (c_hx == b_hx));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // 0 none, 1 in window, 2 on evaluation line, 3 stray early,
    // 4 in window + stray, 5 in window + evaluation line.
    task automatic run_frame(input int mode);
        a_hy = -1;
        b_hy = -1;
        a_hx = $urandom_range(0, W - 1);
        b_hx = $urandom_range(0, W - 1);
        case (mode)
            1: a_hy = $urandom_range(NF, NF + TOL);
            2: a_hy = EVAL_HY;
            3: a_hy = $urandom_range(0, NF - 1);
            4: begin a_hy = $urandom_range(NF, NF + TOL); b_hy = $urandom_range(0, NF - 1); end
            5: begin a_hy = $urandom_range(NF, NF + TOL); b_hy = EVAL_HY; end
            default: ;
        endcase
        run_cycles(FRAME);
    endtask

    initial begin
        int r;
        rst_h_n = 1'b0;
        enable = 1'b0;
        ppu_frame_i = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        cycle();
        check_val("rst_hx", hx, 0);
        check_val("rst_hy", hy, 0);
        check_val("rst_hdmi_on", hdmi_on, 1);
        check_val("rst_lock_state", lock_state, 0);
        check_val("rst_resync", resync_cnt, 0);
        rst_h_n = 1'b1;

        // Counters free-run through a whole frame with the sequencer idle.
        run_cycles(FRAME + 5);
        check_val("idle_state", lock_state, 0);

        // Two good frames lock; three late frames drop back to SEEK.
        enable = 1'b1;
        run_frame(1);
        run_frame(1);
        check_val("lock_up", locked, 1);
        run_frame(2);
        run_frame(2);
        run_frame(2);
        check_val("lock_lost_state", lock_state, 1);
        check_val("lock_lost_nes", locked, 0);
`ifdef HDMI_SEQ_STATS_EN
        check_val("resync_after_loss", resync_cnt, 1);
`else
        check_val("resync_after_loss", resync_cnt, 0);
`endif

        // Randomized frames with occasional phase slips.
        for (int f = 0; f < 50; f++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) run_frame(1);
            else run_frame(r - 5);
            if ($urandom_range(0, 3) == 0) run_cycles($urandom_range(1, FRAME - 1));
        end

        // Enable drop mid-frame while locked.
        run_frame(1);
        run_frame(1);
        check_val("pre_drop_locked", locked, 1);
        run_cycles(W * 5 + 7);
        enable = 1'b0;
        cycle();
        check_val("drop_state", lock_state, 0);
        check_val("drop_nes_on", nes_on, 0);
        run_cycles(FRAME);
        enable = 1'b1;

        // Reset mid-line while locked.
        run_frame(1);
        run_frame(1);
        check_val("pre_reset_locked", locked, 1);
        run_cycles(W + 9);
        rst_h_n = 1'b0;
        cycle();
        check_val("mid_rst_hx", hx, 0);
        check_val("mid_rst_hy", hy, 0);
        check_val("mid_rst_state", lock_state, 0);
        check_val("mid_rst_nes_on", nes_on, 0);
        check_val("mid_rst_new_frame", new_frame, 0);
        check_val("mid_rst_resync", resync_cnt, 0);
        rst_h_n = 1'b1;
        run_frame(1);
        run_frame(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
